// File: rtl/conv_window_buf.sv
// Streaming KxK sliding-window generator with stride, output coordinates and frame-done pulse.
// Pixels arrive in raster order under valid_in. K-1 line buffers feed a KxK shift window.
module conv_window_buf #(
  parameter int unsigned WIDTH     = 15,
  parameter int unsigned HEIGHT    = 19,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned K         = 3,
  parameter int unsigned STRIDE    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic [DATA_BITS-1:0]         data_in,
  output logic [K*K*DATA_BITS-1:0]     window_out,
  output logic                         valid_out,
  output logic [$clog2(HEIGHT)-1:0]    out_row,
  output logic [$clog2(WIDTH)-1:0]     out_col,
  output logic                         frame_done
);

  localparam int unsigned RW = $clog2(HEIGHT);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned NL = K - 1;

  logic [RW-1:0]          row;
  logic [CW-1:0]          col;
  logic [DATA_BITS-1:0]   line_mem [NL][WIDTH];
  logic [DATA_BITS-1:0]   win      [K][K];
  logic [DATA_BITS-1:0]   win_nxt  [K][K];
  logic [DATA_BITS-1:0]   col_vec  [K];
  logic [K*K*DATA_BITS-1:0] win_flat_c;
  logic                   col_last_c;
  logic                   row_last_c;
  logic                   emit_c;
  logic [31:0]            row_off;
  logic [31:0]            col_off;

  assign col_last_c = (col == CW'(WIDTH - 1));
  assign row_last_c = (row == RW'(HEIGHT - 1));

  // Offsets of the candidate window's top-left corner relative to the current pixel.
  assign row_off = 32'(row) - 32'(K - 1);
  assign col_off = 32'(col) - 32'(K - 1);

  // A window is emitted only when fully inside the frame and aligned to the stride grid.
  assign emit_c = valid_in
                  && (32'(row) >= 32'(K - 1))
                  && (32'(col) >= 32'(K - 1))
                  && ((row_off % 32'(STRIDE)) == 32'd0)
                  && ((col_off % 32'(STRIDE)) == 32'd0);

  // Column of K pixels ending at the incoming pixel: oldest line at index 0.
  always_comb begin
    for (int i = 0; i < K; i++) col_vec[i] = '0;
    col_vec[K-1] = data_in;
    for (int l = 0; l < NL; l++) col_vec[K-2-l] = line_mem[l][col];
  end

  // Next window: shift left one column and append the new pixel column on the right.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_nxt[i][j] = (j == K - 1) ? col_vec[i] : win[i][(j+1) % K];
      end
    end
  end

  // Flatten the next window into element order e = i*K + j.
  always_comb begin
    win_flat_c = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_flat_c[(i*K+j)*DATA_BITS +: DATA_BITS] = win_nxt[i][j];
      end
    end
  end

  // Raster position counters; wrap at the frame end so the next pixel starts a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (valid_in) begin
      if (col_last_c) begin
        col <= '0;
        row <= row_last_c ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers and window registers; contents are don't-care until refilled in-frame.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      line_mem[0][col] <= data_in;
      for (int l = 1; l < NL; l++) line_mem[l][col] <= line_mem[l-1][col];
      win <= win_nxt;
    end
  end

  // Registered outputs; window and coordinates hold between emissions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      window_out <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      valid_out  <= emit_c;
      frame_done <= valid_in && col_last_c && row_last_c;
      if (emit_c) begin
        window_out <= win_flat_c;
        out_row    <= RW'(row_off);
        out_col    <= CW'(col_off);
      end
    end
  end

endmodule

// File: tb/tb_conv_window_buf.sv
// Bench for conv_window_buf: three geometries, a frame-level window model and literal anchors.
module tb_conv_window_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // id 0: 15x19 K3 S1, id 1: 15x19 K3 S2, id 2: 8x6 K5 S1
  logic              v0, v1, v2;
  logic [31:0]       d0, d1, d2;
  logic [9*32-1:0]   w0, w1;
  logic [25*32-1:0]  w2;
  logic              vo0, vo1, vo2, fd0, fd1, fd2;
  logic [4:0]        r0, r1;
  logic [3:0]        c0, c1;
  logic [2:0]        r2, c2;

  conv_window_buf #(.WIDTH(15), .HEIGHT(19), .DATA_BITS(32), .K(3), .STRIDE(1)) u_def (
    .clk(clk), .rst_n(rst_n), .valid_in(v0), .data_in(d0), .window_out(w0),
    .valid_out(vo0), .out_row(r0), .out_col(c0), .frame_done(fd0));

  conv_window_buf #(.WIDTH(15), .HEIGHT(19), .DATA_BITS(32), .K(3), .STRIDE(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .valid_in(v1), .data_in(d1), .window_out(w1),
    .valid_out(vo1), .out_row(r1), .out_col(c1), .frame_done(fd1));

  conv_window_buf #(.WIDTH(8), .HEIGHT(6), .DATA_BITS(32), .K(5), .STRIDE(1)) u_k5 (
    .clk(clk), .rst_n(rst_n), .valid_in(v2), .data_in(d2), .window_out(w2),
    .valid_out(vo2), .out_row(r2), .out_col(c2), .frame_done(fd2));

  typedef struct {
    int id;
    int row;
    int col;
    int base;
    bit cap;
  } exp_t;

  exp_t         q[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           win_cnt[3];
  int           fd_cnt[3];
  int           last_r[3];
  int           last_c[3];
  logic [799:0] last_w[3];
  logic [799:0] cap_win;
  int           below_cnt;

  int lit_first[9]  = '{0, 1, 2, 15, 16, 17, 30, 31, 32};
  int lit_last[9]   = '{252, 253, 254, 267, 268, 269, 282, 283, 284};
  int lit_b1000[9]  = '{1000, 1001, 1002, 1015, 1016, 1017, 1030, 1031, 1032};
  int lit_b500[9]   = '{500, 501, 502, 515, 516, 517, 530, 531, 532};
  int lit_k5row0[5] = '{0, 1, 2, 3, 4};

  function automatic int gw(input int id); return (id == 2) ? 8 : 15; endfunction
  function automatic int gh(input int id); return (id == 2) ? 6 : 19; endfunction
  function automatic int gk(input int id); return (id == 2) ? 5 : 3; endfunction
  function automatic int gs(input int id); return (id == 1) ? 2 : 1; endfunction

  function automatic logic [799:0] pack9(input int a[9]);
    logic [799:0] v = '0;
    for (int e = 0; e < 9; e++) v[e*32 +: 32] = 32'(a[e]);
    return v;
  endfunction

  task automatic cmp(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_w(input string name, input logic [799:0] act, input logic [799:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: every stride-aligned window position of a frame, in raster order.
  task automatic push_frame(input int id, input int base);
    exp_t e;
    int W, H, K, S;
    W = gw(id); H = gh(id); K = gk(id); S = gs(id);
    for (int r = 0; r + K <= H; r += S) begin
      for (int c = 0; c + K <= W; c += S) begin
        e.id = id; e.row = r; e.col = c; e.base = base; e.cap = (r == 0 && c == 0);
        q.push_back(e);
      end
    end
  endtask

  task automatic set_in(input int id, input logic v, input logic [31:0] d);
    case (id)
      0: begin v0 = v; d0 = d; end
      1: begin v1 = v; d1 = d; end
      default: begin v2 = v; d2 = d; end
    endcase
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Feed pixel value base + r*W + c in raster order; limit < 0 means the whole frame.
  task automatic send_frame(input int id, input int base, input int gap, input int limit);
    int n, W, H;
    n = 0; W = gw(id); H = gh(id);
    push_frame(id, base);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n == limit) return;
        while ($urandom_range(0, 99) < gap) idle_cycle();
        set_in(id, 1'b1, 32'(base + r*W + c));
        @(posedge clk); #1;
        set_in(id, 1'b0, 32'd0);
        n++;
      end
    end
  endtask

  task automatic drain();
    v0 = 0; v1 = 0; v2 = 0;
    repeat (4) idle_cycle();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin win_cnt[i] = 0; fd_cnt[i] = 0; end
    cap_win = '0;
    below_cnt = 0;
  endtask

  // Per-cycle check of one DUT against the head of the model queue.
  task automatic chk(input int id, input logic vo, input logic fd, input logic [799:0] w,
                     input int orow, input int ocol);
    exp_t e;
    logic [799:0] ew;
    int K, W;
    K = gk(id); W = gw(id);
    if (fd) begin
      fd_cnt[id]++;
      cmp("frame_done_with_last_window", longint'(vo), 1);
    end
    if (vo) begin
      win_cnt[id]++;
      if (id == 1) cmp("stride2_even_coord", longint'((orow | ocol) & 1), 0);
      if (q.size() == 0) begin
        cmp("unexpected_window", 1, 0);
      end else begin
        e = q.pop_front();
        cmp("window_dut", id, e.id);
        cmp("out_row", orow, e.row);
        cmp("out_col", ocol, e.col);
        ew = '0;
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            ew[(i*K+j)*32 +: 32] = 32'(e.base + (e.row + i)*W + e.col + j);
            if (e.base >= 1000 && w[(i*K+j)*32 +: 32] < 32'd1000) below_cnt++;
          end
        end
        cmp_w("window_data", w, ew);
        if (e.cap) cap_win = w;
      end
      last_w[id] = w; last_r[id] = orow; last_c[id] = ocol;
    end else begin
      cmp_w("hold_window", w, last_w[id]);
      cmp("hold_row", orow, last_r[id]);
      cmp("hold_col", ocol, last_c[id]);
    end
  endtask

  // Sample all DUTs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      cmp("reset_valid_done", longint'({vo0, vo1, vo2, fd0, fd1, fd2}), 0);
      cmp("reset_window", longint'(|{w0, w1, w2}), 0);
      cmp("reset_coord", longint'(|{r0, c0, r1, c1, r2, c2}), 0);
      for (int i = 0; i < 3; i++) begin last_w[i] = '0; last_r[i] = 0; last_c[i] = 0; end
    end else begin
      chk(0, vo0, fd0, 800'(w0), int'(r0), int'(c0));
      chk(1, vo1, fd1, 800'(w1), int'(r1), int'(c1));
      chk(2, vo2, fd2, 800'(w2), int'(r2), int'(c2));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [799:0] k5exp;
    v0 = 0; v1 = 0; v2 = 0; d0 = 0; d1 = 0; d2 = 0;
    clear_counts();
    for (int i = 0; i < 3; i++) begin last_w[i] = '0; last_r[i] = 0; last_c[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Continuous default frame
    clear_counts();
    send_frame(0, 0, 0, -1);
    drain();
    cmp("t1_windows", win_cnt[0], 221);
    cmp("t1_frame_done", fd_cnt[0], 1);
    cmp("t1_queue_empty", q.size(), 0);
    cmp_w("t1_first_window", cap_win, pack9(lit_first));
    cmp_w("t1_last_window", last_w[0], pack9(lit_last));
    cmp("t1_last_row", last_r[0], 16);
    cmp("t1_last_col", last_c[0], 12);

    // Same frame with ~40% idle cycles
    clear_counts();
    send_frame(0, 0, 40, -1);
    drain();
    cmp("t2_windows", win_cnt[0], 221);
    cmp("t2_frame_done", fd_cnt[0], 1);
    cmp("t2_queue_empty", q.size(), 0);
    cmp_w("t2_first_window", cap_win, pack9(lit_first));

    // Back-to-back frames, second offset by 1000
    clear_counts();
    send_frame(0, 0, 0, -1);
    send_frame(0, 1000, 0, -1);
    drain();
    cmp("t3_windows", win_cnt[0], 442);
    cmp("t3_frame_done", fd_cnt[0], 2);
    cmp("t3_queue_empty", q.size(), 0);
    cmp_w("t3_second_first_window", cap_win, pack9(lit_b1000));
    cmp("t3_values_below_1000", below_cnt, 0);

    // Reset mid-row 7, then a fresh frame
    clear_counts();
    send_frame(0, 0, 20, 7*15 + 5);
    rst_n = 1'b0;
    repeat (3) idle_cycle();
    q.delete();
    clear_counts();
    rst_n = 1'b1;
    send_frame(0, 500, 0, -1);
    drain();
    cmp("t4_windows", win_cnt[0], 221);
    cmp("t4_frame_done", fd_cnt[0], 1);
    cmp("t4_queue_empty", q.size(), 0);
    cmp_w("t4_first_window", cap_win, pack9(lit_b500));

    // Stride 2 with gaps
    clear_counts();
    send_frame(1, 0, 30, -1);
    drain();
    cmp("t5_windows", win_cnt[1], 63);
    cmp("t5_frame_done", fd_cnt[1], 1);
    cmp("t5_queue_empty", q.size(), 0);
    cmp("t5_last_row", last_r[1], 16);
    cmp("t5_last_col", last_c[1], 12);

    // K=5 on an 8x6 image
    clear_counts();
    send_frame(2, 0, 0, -1);
    drain();
    cmp("t6_windows", win_cnt[2], 8);
    cmp("t6_frame_done", fd_cnt[2], 1);
    cmp("t6_queue_empty", q.size(), 0);
    k5exp = '0;
    for (int e = 0; e < 5; e++) k5exp[e*32 +: 32] = 32'(lit_k5row0[e]);
    cmp_w("t6_first_row", 800'(cap_win[159:0]), k5exp);
    cmp("t6_elem24", longint'(cap_win[24*32 +: 32]), 36);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_buf.md
Name: conv_window_buf

Overview:
Parametrised streaming sliding-window generator feeding the convolution PE array. Accepts one raster-order pixel per cycle under valid_in, with arbitrary gaps. Emits a registered KxK window with its output coordinates, supporting configurable kernel size and stride. Successor to the fixed 3x3 conv buffer: adds input handshake, stride, coordinate outputs, a frame-done pulse and automatic back-to-back frame handling.

Parameters:
WIDTH, 15, image width in pixels (>= K)
HEIGHT, 19, image height in pixels (>= K)
DATA_BITS, 32, pixel width
K, 3, kernel size (KxK window, 2..7)
STRIDE, 1, window stride in both axes (1..K)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  data_in is valid this cycle; pixel accepted on the same edge
data_in  input  DATA_BITS  pixel, raster order, row-major
window_out  output  K*K*DATA_BITS  window; element e=i*K+j at bits [e*DATA_BITS +: DATA_BITS]
valid_out  output  1  window_out/out_row/out_col valid for exactly this cycle
out_row  output  $clog2(HEIGHT)  row index of the window's top-left pixel
out_col  output  $clog2(WIDTH)  column index of the window's top-left pixel
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (async assert, sync deassert): all outputs 0; col/row counters 0; line-buffer contents are don't-care and never reach window_out before being overwritten in the current frame.
- Storage: K-1 line buffers of WIDTH entries plus a KxK register window; line buffers advance only when valid_in=1. No pixel is dropped; no backpressure exists.
- Counters: col increments on each accepted pixel; at WIDTH-1 it wraps to 0 and row increments; at (HEIGHT-1, WIDTH-1) both wrap to 0 and the next accepted pixel starts a new frame. No idle cycles are required between frames.
- Window content: when the pixel at (r,c) is accepted, element i*K+j = pixel (r-K+1+i, c-K+1+j), i,j in 0..K-1, taken from the current frame only.
- Emission condition for accepted pixel (r,c): r>=K-1, c>=K-1, (r-K+1)%STRIDE==0, (c-K+1)%STRIDE==0.
- Latency: valid_out asserts on the cycle after the qualifying pixel's accept edge, for one cycle. out_row=(r-K+1), out_col=(c-K+1) in the same cycle. When valid_out=0, window_out, out_row and out_col hold their last values.
- Windows never straddle rows: columns c<K-1 never emit. Window-register content from the previous row is overwritten before the next emission.
- Frame boundary: row 0..K-2 data from a new frame never combines with lines from the previous frame, because emission requires r>=K-1 in the new frame.
- Outputs per frame: ((HEIGHT-K)/STRIDE+1)*((WIDTH-K)/STRIDE+1) using integer division; trailing rows/columns not reachable by the stride are silently skipped.
- frame_done pulses on the cycle after (HEIGHT-1, WIDTH-1) is accepted. It coincides with the last valid_out if that pixel qualifies.
- valid_in=0 cycles: no state change except valid_out/frame_done deassert.
- Reset mid-frame: all progress discarded; the next accepted pixel is (0,0) of a new frame.
- Arithmetic: counters unsigned, sized $clog2 of their range. Data is passed through unmodified; no arithmetic on pixels.

Test Plan:
- Defaults, continuous valid_in, data_in=r*15+c -> first valid_out one cycle after pixel 32 accepted, window={0,1,2,15,16,17,30,31,32}, out_row=0, out_col=0. 221 windows/frame; last window top-left (16,12) = {252..254,267..269,282..284}. frame_done once.
- Same frame with random valid_in gaps (~40% idle) -> identical window sequence and coordinates as the continuous case; only the timing differs.
- STRIDE=2 -> 63 windows (9 rows x 7 cols). out_col steps 0,2,..,12; out_row steps 0,2,..,16. Windows are never emitted on odd coordinates.
- Two back-to-back frames, second frame data offset by 1000 -> second frame's first window = {1000,1001,1002,1015,...,1032}. No window contains values below 1000.
- rst_n pulsed low mid-row 7, then a fresh frame is sent -> all outputs 0 during reset; the first post-reset window is (0,0) with the new frame's data; the total of 221 windows follows.
- K=5, WIDTH=8, HEIGHT=6 -> 2x4=8 windows; first window elements 0..4 = {0,1,2,3,4}, element 24 = 36.
